wbu_stage: RTL

WBU_STAGE -- requirements
Module: wbu_stage

---
 rtl/wbu_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wbu_stage.sv
// wbu_stage: single-entry write-back stage; selects and extends the result,
// drives the regfile write port, counts retirements and halts on EBREAK.
`default_nettype none

module wbu_stage #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_rdwen,
  input  logic [REG_ADDRW-1:0] i_rdaddr,
  input  logic [1:0]           i_rdsel,
  input  logic [2:0]           i_ldfunc3,
  input  logic [CPU_WIDTH-1:0] i_alures,
  input  logic [CPU_WIDTH-1:0] i_lddata,
  input  logic [CPU_WIDTH-1:0] i_csrdata,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic                 i_ebreak,
  input  logic                 i_a0zero,
  output logic                 o_rf_wen,
  output logic [REG_ADDRW-1:0] o_rf_waddr,
  output logic [CPU_WIDTH-1:0] o_rf_wdata,
  output logic                 o_commit,
  output logic [CPU_WIDTH-1:0] o_commit_pc,
  output logic [63:0]          o_instret,
  output logic                 o_halt,
  output logic                 o_good_trap
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 valid_q;
  logic                 rdwen_q;
  logic [REG_ADDRW-1:0] rdaddr_q;
  logic [1:0]           rdsel_q;
  logic [2:0]           ldfunc3_q;
  logic [CPU_WIDTH-1:0] alures_q, lddata_q, csrdata_q, pc_q;
  logic                 ebreak_q;
  logic [63:0]          instret_q, instret_d;
  logic                 halt_q, halt_d;
  logic                 good_trap_q, good_trap_d;
  logic                 xfer;
  logic                 halt_now;
  logic [CPU_WIDTH-1:0] ld_ext;

  assign o_ready  = (state_q == ST_RUN);
  assign xfer     = i_valid && o_ready;
  assign halt_now = (state_q == ST_RUN) && valid_q && ebreak_q;

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    good_trap_d = good_trap_q;
    instret_d   = instret_q + {63'd0, valid_q};
    if (halt_now) begin
      state_d     = ST_HALT;
      halt_d      = 1'b1;
      good_trap_d = i_a0zero;
    end
  end

  // Load data arrives right-aligned; extend per RV64 funct3.
  always_comb begin
    ld_ext = '0;
    case (ldfunc3_q)
      3'd0:    ld_ext = {{(CPU_WIDTH-8){lddata_q[7]}},   lddata_q[7:0]};
      3'd1:    ld_ext = {{(CPU_WIDTH-16){lddata_q[15]}}, lddata_q[15:0]};
      3'd2:    ld_ext = {{(CPU_WIDTH-32){lddata_q[31]}}, lddata_q[31:0]};
      3'd3:    ld_ext = lddata_q;
      3'd4:    ld_ext = {{(CPU_WIDTH-8){1'b0}},  lddata_q[7:0]};
      3'd5:    ld_ext = {{(CPU_WIDTH-16){1'b0}}, lddata_q[15:0]};
      3'd6:    ld_ext = {{(CPU_WIDTH-32){1'b0}}, lddata_q[31:0]};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    o_rf_wdata = alures_q;
    case (rdsel_q)
      2'd0:    o_rf_wdata = alures_q;
      2'd1:    o_rf_wdata = ld_ext;
      2'd2:    o_rf_wdata = pc_q + CPU_WIDTH'(4);
      default: o_rf_wdata = csrdata_q;
    endcase
  end

  assign o_rf_wen    = valid_q && rdwen_q && (rdaddr_q != '0);
  assign o_rf_waddr  = rdaddr_q;
  assign o_commit    = valid_q;
  assign o_commit_pc = pc_q;
  assign o_instret   = instret_q;
  assign o_halt      = halt_q;
  assign o_good_trap = good_trap_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      valid_q     <= 1'b0;
      rdwen_q     <= 1'b0;
      rdaddr_q    <= '0;
      rdsel_q     <= '0;
      ldfunc3_q   <= '0;
      alures_q    <= '0;
      lddata_q    <= '0;
      csrdata_q   <= '0;
      pc_q        <= '0;
      ebreak_q    <= 1'b0;
      instret_q   <= '0;
      halt_q      <= 1'b0;
      good_trap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instret_q   <= instret_d;
      halt_q      <= halt_d;
      good_trap_q <= good_trap_d;
      valid_q     <= xfer;
      // Fields are only refreshed on a transfer; valid_q alone marks them live.
      if (xfer) begin
        rdwen_q   <= i_rdwen;
        rdaddr_q  <= i_rdaddr;
        rdsel_q   <= i_rdsel;
        ldfunc3_q <= i_ldfunc3;
        alures_q  <= i_alures;
        lddata_q  <= i_lddata;
        csrdata_q <= i_csrdata;
        pc_q      <= i_pc;
        ebreak_q  <= i_ebreak;
      end
    end
  end

endmodule

`default_nettype wire
